// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the 2048 board display path: pixel region codes,
// default board geometry and screen/frame colours. The per-tile renderer
// takes its tile size from TILE_SIZE here so both sides agree.
// ----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        REG_BLANK = 2'd0,
        REG_OUT   = 2'd1,
        REG_FRAME = 2'd2,
        REG_TILE  = 2'd3
    } region_t;

    localparam int unsigned VGA_H_ACTIVE = 1024;
    localparam int unsigned VGA_V_ACTIVE = 768;
    localparam int unsigned BOARD_ORG_X  = 186;
    localparam int unsigned BOARD_ORG_Y  = 58;
    localparam int unsigned TILE_SIZE    = 148;
    localparam int unsigned TILE_GAP     = 12;
    localparam int unsigned BOARD_SIDE   = 4 * TILE_SIZE + 5 * TILE_GAP;
    localparam int unsigned RENDER_LAT   = 2;

    localparam logic [11:0] BG_COLOR_DEF    = 12'hFFE;
    localparam logic [11:0] FRAME_COLOR_DEF = 12'hBAA;

    // Tile (row, col) lives at board[4*(4*row+col) +: 4].
    function automatic logic [3:0] board_nibble(input logic [63:0] b,
                                                input logic [1:0]  row,
                                                input logic [1:0]  col);
        return b[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/board_axis_decode.sv
// ----------------------------------------------------------------------------
// board_axis_decode
// Decodes one axis of the board from an offset relative to the board's outer
// edge. Uses a compare chain against the constant tile start positions, so no
// divider is needed.
//   i_offset   in  12  position minus board origin (wraps for pixels before it)
//   o_in_board out  1  offset lies within the board side (frame included)
//   o_in_tile  out  1  offset lies inside one tile span
//   o_index    out  2  tile index along this axis (valid with o_in_tile)
//   o_local    out 12  tile-local coordinate 0..TILE-1 (0 when not in a tile)
// ----------------------------------------------------------------------------
module board_axis_decode #(
    parameter int unsigned TILE = 148,
    parameter int unsigned GAP  = 12
) (
    input  logic [11:0] i_offset,
    output logic        o_in_board,
    output logic        o_in_tile,
    output logic [1:0]  o_index,
    output logic [11:0] o_local
);

    localparam int unsigned PITCH = TILE + GAP;
    localparam int unsigned SIDE  = 4 * TILE + 5 * GAP;

    always_comb begin
        o_in_board = (i_offset < 12'(SIDE));
        o_in_tile  = 1'b0;
        o_index    = '0;
        o_local    = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            if ((i_offset >= 12'(c * PITCH + GAP)) &&
                (i_offset <  12'(c * PITCH + GAP + TILE))) begin
                o_in_tile = 1'b1;
                o_index   = 2'(c);
                o_local   = i_offset - 12'(c * PITCH + GAP);
            end
        end
    end

endmodule

// File: rtl/board_vga_scanner.sv
// ----------------------------------------------------------------------------
// board_vga_scanner
// Maps the global raster position onto the 4x4 board, feeds the per-tile
// renderer and composites its pixel with frame/background colours.
//   clk          in   1  pixel clock
//   rst          in   1  asynchronous active-low reset
//   h_cnt/v_cnt  in  12  global raster position
//   board        in  64  board from game logic, nibble per tile
//   board_update in   1  strobe: capture board
//   tile_state   out  4  tile exponent to renderer
//   tile_h_cnt   out 12  tile-local column
//   tile_v_cnt   out 12  tile-local line
//   tile_en      out  1  pixel lies inside a tile
//   tile_pixel   in  12  renderer output, DS_LAT cycles after tile_*
//   vga_data     out 12  final RGB444, DS_LAT+2 cycles after h_cnt/v_cnt
// ----------------------------------------------------------------------------
module board_vga_scanner
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned ORIGIN_X    = BOARD_ORG_X,
    parameter int unsigned ORIGIN_Y    = BOARD_ORG_Y,
    parameter int unsigned TILE        = TILE_SIZE,
    parameter int unsigned GAP         = TILE_GAP,
    parameter int unsigned DS_LAT      = RENDER_LAT,
    parameter logic [11:0] BG_COLOR    = BG_COLOR_DEF,
    parameter logic [11:0] FRAME_COLOR = FRAME_COLOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] h_cnt,
    input  logic [11:0] v_cnt,
    input  logic [63:0] board,
    input  logic        board_update,
    output logic [3:0]  tile_state,
    output logic [11:0] tile_h_cnt,
    output logic [11:0] tile_v_cnt,
    output logic        tile_en,
    input  logic [11:0] tile_pixel,
    output logic [11:0] vga_data
);

    logic [63:0] r_pending;
    logic [63:0] r_shadow;
    logic [3:0]  r_tile_state;
    logic [11:0] r_tile_h_cnt;
    logic [11:0] r_tile_v_cnt;
    logic        r_tile_en;
    logic [11:0] r_vga_data;
    region_t     r_region_dl [DS_LAT+1];

    logic [11:0] w_dx, w_dy;
    logic        w_x_in_board, w_x_in_tile, w_y_in_board, w_y_in_tile;
    logic [1:0]  w_col, w_row;
    logic [11:0] w_x_local, w_y_local;
    logic        w_frame_tick;
    region_t     w_region;

    assign w_dx         = h_cnt - 12'(ORIGIN_X);
    assign w_dy         = v_cnt - 12'(ORIGIN_Y);
    assign w_frame_tick = (h_cnt == '0) && (v_cnt == 12'(V_ACTIVE));

    board_axis_decode #(.TILE(TILE), .GAP(GAP)) u_x_decode (
        .i_offset   (w_dx),
        .o_in_board (w_x_in_board),
        .o_in_tile  (w_x_in_tile),
        .o_index    (w_col),
        .o_local    (w_x_local)
    );

    board_axis_decode #(.TILE(TILE), .GAP(GAP)) u_y_decode (
        .i_offset   (w_dy),
        .o_in_board (w_y_in_board),
        .o_in_tile  (w_y_in_tile),
        .o_index    (w_row),
        .o_local    (w_y_local)
    );

    always_comb begin
        w_region = REG_FRAME;
        if ((h_cnt >= 12'(H_ACTIVE)) || (v_cnt >= 12'(V_ACTIVE)))
            w_region = REG_BLANK;
        else if (!(w_x_in_board && w_y_in_board))
            w_region = REG_OUT;
        else if (w_x_in_tile && w_y_in_tile)
            w_region = REG_TILE;
    end

    // Double buffer: display only ever reads r_shadow, which changes at the
    // first blanking line. An update landing on that same pixel bypasses
    // r_pending so it is not lost for a whole frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
            r_shadow  <= '0;
        end else begin
            if (board_update)
                r_pending <= board;
            if (w_frame_tick)
                r_shadow <= board_update ? board : r_pending;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tile_en    <= 1'b0;
            r_tile_state <= '0;
            r_tile_h_cnt <= '0;
            r_tile_v_cnt <= '0;
        end else if (w_region == REG_TILE) begin
            r_tile_en    <= 1'b1;
            r_tile_state <= board_nibble(r_shadow, w_row, w_col);
            r_tile_h_cnt <= w_x_local;
            r_tile_v_cnt <= w_y_local;
        end else begin
            r_tile_en    <= 1'b0;
            r_tile_state <= '0;
            r_tile_h_cnt <= '0;
            r_tile_v_cnt <= '0;
        end
    end

    // Entry 0 is aligned with tile_*; entry DS_LAT lines up with tile_pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i <= DS_LAT; i++)
                r_region_dl[i] <= REG_BLANK;
        end else begin
            r_region_dl[0] <= w_region;
            for (int unsigned i = 1; i <= DS_LAT; i++)
                r_region_dl[i] <= r_region_dl[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vga_data <= '0;
        end else begin
            case (r_region_dl[DS_LAT])
                REG_OUT:   r_vga_data <= BG_COLOR;
                REG_FRAME: r_vga_data <= FRAME_COLOR;
                REG_TILE:  r_vga_data <= tile_pixel;
                default:   r_vga_data <= '0;
            endcase
        end
    end

    assign tile_en    = r_tile_en;
    assign tile_state = r_tile_state;
    assign tile_h_cnt = r_tile_h_cnt;
    assign tile_v_cnt = r_tile_v_cnt;
    assign vga_data   = r_vga_data;

endmodule
